// File: rtl/dds_ctrl_pkg.sv
// Purpose : shared types and constants for the chaotic DDS hop sequencer.
// Latency : n/a (package only).
// Backpressure: n/a (package only).
//
// Contents: hop FSM state encoding, default state-word width and the
// x/y/z field positions inside a {x,y,z} state word.
package dds_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_WAIT = 3'd2,
    ST_LOAD = 3'd3,
    ST_RUN  = 3'd4
  } hop_state_t;

  localparam int DEF_PHASE_WIDTH = 32;
  localparam int STATE_W         = 3 * DEF_PHASE_WIDTH;

  // Field index within a state word; x occupies the most significant slot.
  localparam int FIELD_X = 2;
  localparam int FIELD_Y = 1;
  localparam int FIELD_Z = 0;

  localparam int X_LSB = FIELD_X * DEF_PHASE_WIDTH;
  localparam int Y_LSB = FIELD_Y * DEF_PHASE_WIDTH;
  localparam int Z_LSB = FIELD_Z * DEF_PHASE_WIDTH;

  // LSB position of a field for an arbitrary phase width.
  function automatic int field_lsb(input int field, input int phase_width);
    return field * phase_width;
  endfunction

endpackage

// File: rtl/dds_hop_timer.sv
// Purpose : loadable up-counter with terminal-count flag (hop and timeout timers).
// Latency : clear/increment take effect on the next clk edge; tc is combinational from the count.
// Backpressure: none; the count holds at the terminal value instead of wrapping.
//
// Ports: clk, rst (async active-high), load (reset count to 0), inc (count up),
//        last (terminal value), tc (count == last).
module dds_hop_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         inc,
  input  logic [W-1:0] last,
  output logic         tc
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= '0;
    end else if (inc && !tc) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tc = (cnt == last);

endmodule

// File: rtl/dds_hop_scheduler.sv
// Purpose : per-hop sequencer between the chaotic state generator and the DDS core.
// Latency : en in IDLE -> dds_load 3 cycles later with an immediate valid; CTRL cycles load-to-load.
// Backpressure: none; a missing generator result times out after TIMEOUT cycles and old states are reused.
//
// Ports: clk, rst (async active-high), en, err_clr, ch0/ch1_mod_req, chaotic_valid,
//        ch0/ch1_state_in -> chaotic_ctrl, dds_load, ch0/ch1_state_out, ch0/ch1_mod,
//        hop_cnt, timeout_err, busy. All outputs are registered.
module dds_hop_scheduler
  import dds_ctrl_pkg::*;
#(
  parameter int PHASE_WIDTH = 32,
  parameter int CTRL        = 1000,
  parameter int TIMEOUT     = 16,
  parameter int HOP_CNT_W   = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     err_clr,
  input  logic                     ch0_mod_req,
  input  logic                     ch1_mod_req,
  input  logic                     chaotic_valid,
  input  logic [3*PHASE_WIDTH-1:0] ch0_state_in,
  input  logic [3*PHASE_WIDTH-1:0] ch1_state_in,
  output logic                     chaotic_ctrl,
  output logic                     dds_load,
  output logic [3*PHASE_WIDTH-1:0] ch0_state_out,
  output logic [3*PHASE_WIDTH-1:0] ch1_state_out,
  output logic                     ch0_mod,
  output logic                     ch1_mod,
  output logic [HOP_CNT_W-1:0]     hop_cnt,
  output logic                     timeout_err,
  output logic                     busy
);

  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  localparam int RUN_W  = $clog2(CTRL + 1);

  // WAIT ends on count TIMEOUT-1 (TIMEOUT cycles). RUN covers CTRL-3 cycles,
  // i.e. counts 0..CTRL-4, so LOAD+RUN+REQ+WAIT sums to CTRL.
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
  localparam logic [RUN_W-1:0]  RUN_LAST  = RUN_W'(CTRL - 4);

  hop_state_t state, state_nxt;
  logic       wait_tc;
  logic       run_tc;
  logic       timeout_hit;

  dds_hop_timer #(.W(WAIT_W)) u_wait_timer (
    .clk  (clk),
    .rst  (rst),
    .load (state == ST_REQ),
    .inc  (state == ST_WAIT),
    .last (WAIT_LAST),
    .tc   (wait_tc)
  );

  dds_hop_timer #(.W(RUN_W)) u_run_timer (
    .clk  (clk),
    .rst  (rst),
    .load (state == ST_LOAD),
    .inc  (state == ST_RUN),
    .last (RUN_LAST),
    .tc   (run_tc)
  );

  // A valid in the same cycle as the timeout wins, so it suppresses the error.
  assign timeout_hit = (state == ST_WAIT) && wait_tc && !chaotic_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (en) state_nxt = ST_REQ;
      ST_REQ:  state_nxt = ST_WAIT;
      ST_WAIT: if (chaotic_valid || wait_tc) state_nxt = ST_LOAD;
      ST_LOAD: state_nxt = ST_RUN;
      ST_RUN:  if (run_tc) state_nxt = en ? ST_REQ : ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Strobes and busy are registered from the next state so they line up
  // exactly with the REQ/LOAD cycles without a decode glitch on the outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chaotic_ctrl  <= 1'b0;
      dds_load      <= 1'b0;
      busy          <= 1'b0;
      ch0_state_out <= '0;
      ch1_state_out <= '0;
      ch0_mod       <= 1'b0;
      ch1_mod       <= 1'b0;
      hop_cnt       <= '0;
      timeout_err   <= 1'b0;
    end else begin
      chaotic_ctrl <= (state_nxt == ST_REQ);
      dds_load     <= (state_nxt == ST_LOAD);
      busy         <= (state_nxt != ST_IDLE);

      if ((state == ST_WAIT) && chaotic_valid) begin
        ch0_state_out <= ch0_state_in;
        ch1_state_out <= ch1_state_in;
      end

      // Mode changes only take effect at a hop boundary.
      if (state == ST_LOAD) begin
        ch0_mod <= ch0_mod_req;
        ch1_mod <= ch1_mod_req;
        hop_cnt <= hop_cnt + 1'b1;
      end

      if (timeout_hit) begin
        timeout_err <= 1'b1;
      end else if (err_clr) begin
        timeout_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dds_hop_scheduler.sv
module tb_dds_hop_scheduler;

  localparam int PW   = 32;
  localparam int SW   = 3 * PW;
  localparam int CTRL = 8;
  localparam int TO   = 16;
  localparam int HW   = 4;
  localparam int NCYC = 3000;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          en = 1'b0;
  logic          err_clr = 1'b0;
  logic          ch0_mod_req = 1'b0;
  logic          ch1_mod_req = 1'b0;
  logic          chaotic_valid = 1'b0;
  logic [SW-1:0] ch0_state_in = '0;
  logic [SW-1:0] ch1_state_in = '0;
  logic          chaotic_ctrl;
  logic          dds_load;
  logic [SW-1:0] ch0_state_out;
  logic [SW-1:0] ch1_state_out;
  logic          ch0_mod;
  logic          ch1_mod;
  logic [HW-1:0] hop_cnt;
  logic          timeout_err;
  logic          busy;

  dds_hop_scheduler #(
    .PHASE_WIDTH (PW),
    .CTRL        (CTRL),
    .TIMEOUT     (TO),
    .HOP_CNT_W   (HW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .en            (en),
    .err_clr       (err_clr),
    .ch0_mod_req   (ch0_mod_req),
    .ch1_mod_req   (ch1_mod_req),
    .chaotic_valid (chaotic_valid),
    .ch0_state_in  (ch0_state_in),
    .ch1_state_in  (ch1_state_in),
    .chaotic_ctrl  (chaotic_ctrl),
    .dds_load      (dds_load),
    .ch0_state_out (ch0_state_out),
    .ch1_state_out (ch1_state_out),
    .ch0_mod       (ch0_mod),
    .ch1_mod       (ch1_mod),
    .hop_cnt       (hop_cnt),
    .timeout_err   (timeout_err),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [SW-1:0] got, input logic [SW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctrl"}, SW'(chaotic_ctrl), '0);
    check({tag, "_load"}, SW'(dds_load), '0);
    check({tag, "_busy"}, SW'(busy), '0);
    check({tag, "_err"}, SW'(timeout_err), '0);
    check({tag, "_hop"}, SW'(hop_cnt), '0);
    check({tag, "_mod0"}, SW'(ch0_mod), '0);
    check({tag, "_mod1"}, SW'(ch1_mod), '0);
    check({tag, "_s0"}, ch0_state_out, '0);
    check({tag, "_s1"}, ch1_state_out, '0);
  endtask

  // Reference model: event times of the next request / load / end of hop,
  // derived from the hop timing rules, plus the values the outputs must hold.
  initial begin
    int            exp_req, exp_load, valid_cyc, run_end, last_req, magic_cyc;
    int            hop_idx, d, r, en_hold, post_rst;
    bit            idle, timed_out, outstanding, rst_done;
    logic          e_err, e_m0, e_m1, n_err;
    logic [HW-1:0] e_hop;
    logic [SW-1:0] e_s0, e_s1;

    exp_req = -1; exp_load = -1; valid_cyc = -1; run_end = -1; last_req = -1; magic_cyc = -1;
    hop_idx = 0; en_hold = 0; post_rst = 0;
    idle = 1'b1; timed_out = 1'b0; rst_done = 1'b0;
    e_err = 1'b0; e_m0 = 1'b0; e_m1 = 1'b0; e_hop = '0; e_s0 = '0; e_s1 = '0;

    #1 rst = 1'b1;
    @(negedge clk);
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    for (int n = 0; n < NCYC; n++) begin
      if (n > 0) @(negedge clk);

      // Outputs of cycle n against the model.
      check("chaotic_ctrl", SW'(chaotic_ctrl), SW'(n == exp_req));
      check("dds_load", SW'(dds_load), SW'(n == exp_load));
      check("busy", SW'(busy), SW'(!idle));
      check("timeout_err", SW'(timeout_err), SW'(e_err));
      check("hop_cnt", SW'(hop_cnt), SW'(e_hop));
      check("ch0_mod", SW'(ch0_mod), SW'(e_m0));
      check("ch1_mod", SW'(ch1_mod), SW'(e_m1));
      check("ch0_state", ch0_state_out, e_s0);
      check("ch1_state", ch1_state_out, e_s1);

      // Inputs of cycle n.
      if (post_rst > 0) post_rst--;
      if (en_hold > 0) en_hold--;
      else if ($urandom_range(0, 39) == 0) en_hold = $urandom_range(1, 15);
      en = (en_hold == 0) && (post_rst == 0);
      err_clr = ($urandom_range(0, 9) == 0);
      if (timed_out && (n == exp_load - 1) && ($urandom_range(0, 1) == 1)) err_clr = 1'b1;
      if ($urandom_range(0, 19) == 0) ch0_mod_req = ~ch0_mod_req;
      if ($urandom_range(0, 19) == 0) ch1_mod_req = ~ch1_mod_req;
      ch0_state_in = {$urandom, $urandom, $urandom};
      ch1_state_in = {$urandom, $urandom, $urandom};
      if (n == magic_cyc) ch0_state_in[SW-1 -: PW] = 32'h793069f2;
      outstanding = (exp_load >= n);
      chaotic_valid = (n == valid_cyc) || (post_rst > 0) ||
                      (!outstanding && ($urandom_range(0, 7) == 0));

      // Model update for cycle n+1.
      n_err = e_err;
      if (timed_out && (n == exp_load - 1)) n_err = 1'b1;
      else if (err_clr) n_err = 1'b0;
      e_err = n_err;

      if ((n == valid_cyc) && (n < exp_load)) begin
        e_s0 = ch0_state_in;
        e_s1 = ch1_state_in;
      end

      if (n == exp_load) begin
        e_m0 = ch0_mod_req;
        e_m1 = ch1_mod_req;
        e_hop = e_hop + 1'b1;
        run_end = n + CTRL - 3;
      end

      if (n == run_end) begin
        if (en) exp_req = n + 1;
        else idle = 1'b1;
      end else if (idle && en) begin
        exp_req = n + 1;
        idle = 1'b0;
      end

      if (n == exp_req) begin
        // d = index of the WAIT cycle carrying valid (0 = first WAIT cycle).
        if (hop_idx < 3) d = 0;
        else if (hop_idx == 3) d = 3;
        else if (hop_idx == 4) d = TO + 2;
        else begin
          r = $urandom_range(0, 9);
          if (r < 6) d = 0;
          else if (r < 8) d = $urandom_range(1, TO - 1);
          else d = $urandom_range(TO - 1, TO + 4);
        end
        valid_cyc = n + 1 + d;
        timed_out = (d >= TO);
        exp_load = n + 2 + (timed_out ? TO - 1 : d);
        if (hop_idx == 3) magic_cyc = valid_cyc;
        last_req = n;
        hop_idx++;
      end

      // Asynchronous reset in the middle of a WAIT phase.
      if (!rst_done && (n >= 400) && (n > last_req) && (n < exp_load - 1)) begin
        en = 1'b0;
        #1 rst = 1'b1;
        #1 check_all_zero("async_rst");
        #1 rst = 1'b0;
        exp_req = -1; exp_load = -1; valid_cyc = -1; run_end = -1;
        idle = 1'b1; timed_out = 1'b0;
        e_err = 1'b0; e_m0 = 1'b0; e_m1 = 1'b0; e_hop = '0; e_s0 = '0; e_s1 = '0;
        post_rst = 7;
        rst_done = 1'b1;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
